// File: rtl/divu_seq_pkg.sv
// Shared definitions for the sequential unsigned divider.
// FSM encoding, funct codes and HI/LO read-select codes.
package divu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] F_divu = 6'd27;
  localparam logic [5:0] F_mfhi = 6'd16;
  localparam logic [5:0] F_mflo = 6'd18;

  localparam logic [1:0] SEL_HI = 2'b10;
  localparam logic [1:0] SEL_LO = 2'b11;

  // A read is requested only when the upper select bit is set.
  function automatic logic is_read(input logic [1:0] s);
    return s[1];
  endfunction

endpackage

// File: rtl/divu_seq_div_step.sv
// One restoring division iteration.
// Shifts {rem,quo} left, trial-subtracts the divisor, restores on borrow.
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem,
  input  logic [WIDTH-1:0] quo,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_n,
  output logic [WIDTH-1:0] quo_n
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           ge;

  // Trial subtraction on WIDTH+1 bits; a fitting difference is < divisor.
  always_comb begin
    shifted = {rem, quo[WIDTH-1]};
    ge      = (shifted >= {1'b0, divisor});
    diff    = shifted - {1'b0, divisor};
    quo_n   = {quo[WIDTH-2:0], ge};
    rem_n   = ge ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/divu_seq.sv
// Multi-cycle unsigned divider with HI/LO result registers.
// One restoring step per cycle; stalls the pipeline on early reads.
module divu_seq
  import divu_seq_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic [1:0]       sel,
  output logic [WIDTH-1:0] hilo_out,
  output logic             busy,
  output logic             stall,
  output logic             done
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_n;
  logic [WIDTH-1:0] quo_n;
  logic             last;
  logic             dvz;

  assign last = (cnt_q == CNT_W'(1));
  assign dvz  = (divisor == '0);

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .rem    (rem_q),
    .quo    (quo_q),
    .divisor(dvs_q),
    .rem_n  (rem_n),
    .quo_n  (quo_n)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic and status outputs.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) state_d = dvz ? DONE : CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    stall = busy & (is_read(sel) | start);
  end

  // Datapath: operand latch, iteration, HI/LO commit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q <= '0;
      quo_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start && dvz) begin
            hi_q <= dividend;
            lo_q <= '1;
          end else if (start) begin
            dvs_q <= divisor;
            quo_q <= dividend;
            rem_q <= '0;
            cnt_q <= CNT_W'(WIDTH);
          end
        end
        CALC: begin
          rem_q <= rem_n;
          quo_q <= quo_n;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last) begin
            hi_q <= rem_n;
            lo_q <= quo_n;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // HI/LO read mux; no read returns zero.
  always_comb begin
    hilo_out = '0;
    unique case (sel)
      SEL_HI:  hilo_out = hi_q;
      SEL_LO:  hilo_out = lo_q;
      default: hilo_out = '0;
    endcase
  end

endmodule

// File: tb/tb_divu_seq.sv
// Directed bench for divu_seq.
// Hand-computed quotients, remainders, latencies and stall behaviour.
module tb_divu_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [1:0]  sel = 2'b00;
  logic [31:0] hilo_out;
  logic        busy;
  logic        stall;
  logic        done;

  int vecs = 0;
  int errs = 0;

  divu_seq #(
    .WIDTH(32),
    .CNT_W(6)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .dividend(dividend),
    .divisor (divisor),
    .sel     (sel),
    .hilo_out(hilo_out),
    .busy    (busy),
    .stall   (stall),
    .done    (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [1:0] s, output logic [31:0] v);
    sel = s;
    #1;
    v = hilo_out;
  endtask

  task automatic run_div(input logic [31:0] dd, input logic [31:0] dv,
                         output int lat, output int bc);
    dividend = dd;
    divisor  = dv;
    start    = 1'b1;
    tick();
    start = 1'b0;
    lat   = 1;
    bc    = 0;
    while (!done && lat < 60) begin
      if (busy) bc++;
      tick();
      lat++;
    end
  endtask

  initial begin
    int          lat;
    int          bc;
    int          bad;
    logic [31:0] v;

    // Reset acts before any clock edge.
    #2;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_stall", {31'd0, stall}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    rd(2'b11, v);
    chk("rst_lo", v, 32'd0);
    rd(2'b10, v);
    chk("rst_hi", v, 32'd0);
    sel = 2'b00;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();

    // 100 / 7: q=14 r=2, done after the 33rd edge, 32 busy cycles.
    run_div(32'd100, 32'd7, lat, bc);
    chk("div1_lat", lat, 33);
    chk("div1_busy", bc, 32);
    chk("div1_done", {31'd0, done}, 32'd1);
    rd(2'b11, v);
    chk("div1_lo", v, 32'd14);
    rd(2'b10, v);
    chk("div1_hi", v, 32'd2);
    rd(2'b00, v);
    chk("sel00", v, 32'd0);
    rd(2'b01, v);
    chk("sel01", v, 32'd0);
    sel = 2'b00;
    tick();
    chk("done_pulse", {31'd0, done}, 32'd0);

    // All-ones / 1 and all-ones / all-ones.
    run_div(32'hFFFF_FFFF, 32'd1, lat, bc);
    rd(2'b11, v);
    chk("max1_lo", v, 32'hFFFF_FFFF);
    rd(2'b10, v);
    chk("max1_hi", v, 32'd0);
    sel = 2'b00;
    tick();
    run_div(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, bc);
    rd(2'b11, v);
    chk("maxm_lo", v, 32'd1);
    rd(2'b10, v);
    chk("maxm_hi", v, 32'd0);
    sel = 2'b00;
    tick();

    // Divide by zero: done on the next cycle, no busy.
    run_div(32'd55, 32'd0, lat, bc);
    chk("dz_lat", lat, 1);
    chk("dz_busy", bc, 0);
    rd(2'b10, v);
    chk("dz_hi", v, 32'd55);
    rd(2'b11, v);
    chk("dz_lo", v, 32'hFFFF_FFFF);
    sel = 2'b00;
    tick();

    // Start with a read in IDLE: old LO returned, no stall.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    sel      = 2'b11;
    #1;
    chk("idle_rd_lo", hilo_out, 32'hFFFF_FFFF);
    chk("idle_rd_stall", {31'd0, stall}, 32'd0);
    tick();
    start = 1'b0;
    sel   = 2'b00;
    for (int i = 1; i < 10; i++) tick();
    // Second start while busy must stall and be ignored.
    dividend = 32'd9;
    divisor  = 32'd3;
    start    = 1'b1;
    #1;
    chk("busy_start_stall", {31'd0, stall}, 32'd1);
    tick();
    start = 1'b0;
    lat   = 0;
    while (!done && lat < 60) begin
      tick();
      lat++;
    end
    chk("ign_done", {31'd0, done}, 32'd1);
    rd(2'b11, v);
    chk("ign_lo", v, 32'd14);
    rd(2'b10, v);
    chk("ign_hi", v, 32'd2);
    sel = 2'b00;
    tick();

    // mflo held from cycle 5: stall until DONE, then reads 14.
    run_div(32'd9, 32'd3, lat, bc);
    sel = 2'b00;
    tick();
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    sel = 2'b11;
    #1;
    bad = 0;
    lat = 0;
    while (busy && lat < 60) begin
      if (!stall) bad++;
      tick();
      lat++;
    end
    chk("rd_stall_held", bad, 0);
    chk("rd_stall_drop", {31'd0, stall}, 32'd0);
    chk("rd_first_val", hilo_out, 32'd14);
    sel = 2'b00;
    tick();

    // Reset mid-division at cycle 20 aborts and clears HI/LO.
    dividend = 32'd100;
    divisor  = 32'd7;
    start    = 1'b1;
    tick();
    start = 1'b0;
    for (int i = 1; i < 20; i++) tick();
    chk("mid_busy", {31'd0, busy}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy", {31'd0, busy}, 32'd0);
    rd(2'b11, v);
    chk("abort_lo", v, 32'd0);
    rd(2'b10, v);
    chk("abort_hi", v, 32'd0);
    sel = 2'b00;
    #1 rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (done || busy) bad++;
      tick();
    end
    chk("abort_no_done", bad, 0);
    run_div(32'd9, 32'd3, lat, bc);
    chk("post_lat", lat, 33);
    rd(2'b11, v);
    chk("post_lo", v, 32'd3);
    rd(2'b10, v);
    chk("post_hi", v, 32'd0);
    sel = 2'b00;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
